deadtime_gen_3ch: RTL and testbench

//  Dead-time inserter for three complementary half-bridge legs (A/B/C). Turns raw

---
 rtl/spwm_pkg.sv | 29 ++
 rtl/deadtime_gen_3ch_if.sv | 27 ++
 rtl/deadtime_channel.sv | 104 ++++++++++
 rtl/deadtime_gen_3ch.sv | 61 ++++++
 tb/tb_deadtime_gen_3ch.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spwm_pkg.sv
// spwm_pkg: shared types and constants for the SPWM gate-drive path.
//  - dt_state_t : per-leg dead-time FSM states
//  - NCH        : number of half-bridge legs (A/B/C)
//  - DT_W       : width of the dead-time counter and dt_cycles input
//  - gap_load() : counter preload that makes a gap last max(dt,1) cycles
package spwm_pkg;

    localparam int NCH  = 3;
    localparam int DT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        H_ON  = 3'd1,
        DT_HL = 3'd2,
        L_ON  = 3'd3,
        DT_LH = 3'd4
    } dt_state_t;

    // The gap state exits on the cycle the counter reads zero, so preloading
    // dt-1 yields exactly dt both-low cycles; dt=0 still spends one cycle.
    function automatic logic [DT_W-1:0] gap_load(input logic [DT_W-1:0] dt);
        if (dt == {DT_W{1'b0}}) begin
            return {DT_W{1'b0}};
        end else begin
            return dt - DT_W'(1);
        end
    endfunction

endpackage

// File: rtl/deadtime_gen_3ch_if.sv
// deadtime_gen_3ch_if: control/status bundle of the three-leg dead-time inserter.
//  en, pwm_in, dt_cycles, fault, fault_clr : modulator/controller -> inserter
//  gate_h, gate_l, fault_lat               : inserter -> output selector
//  master modport = driver side, slave modport = dead-time inserter.
interface deadtime_gen_3ch_if;
    import spwm_pkg::*;

    logic            en;
    logic [NCH-1:0]  pwm_in;
    logic [DT_W-1:0] dt_cycles;
    logic            fault;
    logic            fault_clr;
    logic [NCH-1:0]  gate_h;
    logic [NCH-1:0]  gate_l;
    logic            fault_lat;

    modport master (
        output en, pwm_in, dt_cycles, fault, fault_clr,
        input  gate_h, gate_l, fault_lat
    );

    modport slave (
        input  en, pwm_in, dt_cycles, fault, fault_clr,
        output gate_h, gate_l, fault_lat
    );

endinterface

// File: rtl/deadtime_channel.sv
// deadtime_channel: one complementary half-bridge leg.
//  clk, rst  : clock, asynchronous active-high reset
//  kill_i    : force the leg to IDLE (enable low or fault active/latched)
//  pwm_i     : raw PWM level, 1 requests the high side
//  dt_i      : dead time in clocks, sampled only when a gap is entered
//  gate_h_o  : registered high-side gate
//  gate_l_o  : registered low-side gate
// Gates are decoded from the next state and registered, so both gates are low
// in IDLE and in either gap state and can never be high together.
module deadtime_channel
    import spwm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            kill_i,
    input  logic            pwm_i,
    input  logic [DT_W-1:0] dt_i,
    output logic            gate_h_o,
    output logic            gate_l_o
);

    dt_state_t       state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            gate_h_q, gate_l_q;

    // Next-state and counter logic for the leg FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill_i) begin
            state_d = IDLE;
            cnt_d   = {DT_W{1'b0}};
        end else begin
            case (state_q)
                // Startup always pays a gap toward the requested side.
                IDLE: begin
                    state_d = pwm_i ? DT_LH : DT_HL;
                    cnt_d   = gap_load(dt_i);
                end
                H_ON: begin
                    if (!pwm_i) begin
                        state_d = DT_HL;
                        cnt_d   = gap_load(dt_i);
                    end else begin
                        state_d = H_ON;
                    end
                end
                L_ON: begin
                    if (pwm_i) begin
                        state_d = DT_LH;
                        cnt_d   = gap_load(dt_i);
                    end else begin
                        state_d = L_ON;
                    end
                end
                // A request flip during a gap returns to the side that was
                // just turned off; the other side never conducted, so no risk.
                DT_HL: begin
                    if (pwm_i) begin
                        state_d = H_ON;
                        cnt_d   = {DT_W{1'b0}};
                    end else if (cnt_q == {DT_W{1'b0}}) begin
                        state_d = L_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                DT_LH: begin
                    if (!pwm_i) begin
                        state_d = L_ON;
                        cnt_d   = {DT_W{1'b0}};
                    end else if (cnt_q == {DT_W{1'b0}}) begin
                        state_d = H_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {DT_W{1'b0}};
                end
            endcase
        end
    end

    // State, counter and gate registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {DT_W{1'b0}};
            gate_h_q <= 1'b0;
            gate_l_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gate_h_q <= (state_d == H_ON);
            gate_l_q <= (state_d == L_ON);
        end
    end

    assign gate_h_o = gate_h_q;
    assign gate_l_o = gate_l_q;

endmodule

// File: rtl/deadtime_gen_3ch.sv
// deadtime_gen_3ch: dead-time inserter for three complementary legs (A/B/C).
//  clk, rst : clock, asynchronous active-high reset
//  bus      : slave side of deadtime_gen_3ch_if
//             in : en, pwm_in[NCH], dt_cycles, fault, fault_clr
//             out: gate_h[NCH], gate_l[NCH], fault_lat (all registered)
// Holds the fault latch and drives a shared kill to every leg. A raw fault
// kills in the same cycle it is sampled, so the legs drop to IDLE on the same
// edge that sets fault_lat.
module deadtime_gen_3ch
    import spwm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    deadtime_gen_3ch_if.slave  bus
);

    logic           fault_lat_q, fault_lat_d;
    logic           kill_s;
    logic [NCH-1:0] gate_h_s;
    logic [NCH-1:0] gate_l_s;

    // Fault latch next state: a present fault always wins over a clear.
    always_comb begin
        fault_lat_d = fault_lat_q;
        if (bus.fault) begin
            fault_lat_d = 1'b1;
        end else if (bus.fault_clr) begin
            fault_lat_d = 1'b0;
        end else begin
            fault_lat_d = fault_lat_q;
        end
    end

    // Fault latch register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_lat_q <= 1'b0;
        end else begin
            fault_lat_q <= fault_lat_d;
        end
    end

    assign kill_s = ~bus.en | bus.fault | fault_lat_q;

    for (genvar g = 0; g < NCH; g++) begin : g_leg
        deadtime_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .kill_i   (kill_s),
            .pwm_i    (bus.pwm_in[g]),
            .dt_i     (bus.dt_cycles),
            .gate_h_o (gate_h_s[g]),
            .gate_l_o (gate_l_s[g])
        );
    end

    assign bus.gate_h    = gate_h_s;
    assign bus.gate_l    = gate_l_s;
    assign bus.fault_lat = fault_lat_q;

endmodule

// File: tb/tb_deadtime_gen_3ch.sv
// Self-checking bench for deadtime_gen_3ch: directed latency/fault/reset
// scenarios with hand-computed cycle expectations, then randomized stimulus,
// all compared every cycle against a side/gap reference model.
module tb_deadtime_gen_3ch;
    import spwm_pkg::*;

    localparam int NONE = 0;
    localparam int HS   = 1;
    localparam int LS   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    deadtime_gen_3ch_if bus();

    deadtime_gen_3ch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which side conducts, which side is pending after a
    // gap, and how many more both-low cycles remain before it may turn on.
    int m_active [NCH];
    int m_pend   [NCH];
    int m_wait   [NCH];
    bit m_flat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_active[i] = NONE;
            m_pend[i]   = NONE;
            m_wait[i]   = 0;
        end
        m_flat = 1'b0;
    endfunction

    // One clock edge of the model, using the inputs the DUT samples.
    function automatic void model_step();
        bit kill;
        int gap;
        int want;
        kill = !bus.en || bus.fault || m_flat;
        gap  = (bus.dt_cycles == 8'd0) ? 1 : int'(bus.dt_cycles);
        for (int i = 0; i < NCH; i++) begin
            want = bus.pwm_in[i] ? HS : LS;
            if (kill) begin
                m_active[i] = NONE;
                m_pend[i]   = NONE;
                m_wait[i]   = 0;
            end else if (m_active[i] == NONE && m_pend[i] == NONE) begin
                m_pend[i] = want;
                m_wait[i] = gap;
            end else if (m_pend[i] != NONE) begin
                if (want != m_pend[i]) begin
                    m_active[i] = want;
                    m_pend[i]   = NONE;
                end else begin
                    m_wait[i] = m_wait[i] - 1;
                    if (m_wait[i] == 0) begin
                        m_active[i] = m_pend[i];
                        m_pend[i]   = NONE;
                    end
                end
            end else if (want != m_active[i]) begin
                m_active[i] = NONE;
                m_pend[i]   = want;
                m_wait[i]   = gap;
            end
        end
        m_flat = bus.fault ? 1'b1 : (bus.fault_clr ? 1'b0 : m_flat);
    endfunction

    // Compare process: mid-cycle check of every output against the model.
    initial begin
        model_reset();
        forever begin
            logic [NCH-1:0] eh;
            logic [NCH-1:0] el;
            @(negedge clk);
            if (rst) model_reset();
            for (int i = 0; i < NCH; i++) begin
                eh[i] = (m_active[i] == HS);
                el[i] = (m_active[i] == LS);
            end
            chk("model gate_h", 32'(bus.gate_h), 32'(eh));
            chk("model gate_l", 32'(bus.gate_l), 32'(el));
            chk("model fault_lat", 32'(bus.fault_lat), 32'(m_flat));
            chk("no overlap", 32'(bus.gate_h & bus.gate_l), 32'd0);
            if (!rst) model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic midc();
        @(negedge clk);
    endtask

    task automatic wait_gates(input string name, input logic [2:0] eh, input logic [2:0] el,
                              input int budget);
        int n = 0;
        while ((bus.gate_h !== eh || bus.gate_l !== el) && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.pwm_in = 3'b000;
        bus.dt_cycles = 8'd5;
        bus.fault = 1'b0;
        bus.fault_clr = 1'b0;
        step();
        step();
        midc();
        chk("reset gate_h", 32'(bus.gate_h), 32'd0);
        chk("reset gate_l", 32'(bus.gate_l), 32'd0);
        chk("reset fault_lat", 32'(bus.fault_lat), 32'd0);

        // Startup with dt=5: release at cycle r, low sides on at r+6.
        step();
        rst = 1'b0;
        bus.en = 1'b1;
        repeat (5) step();
        midc();
        chk("startup r+5 gate_l", 32'(bus.gate_l), 32'd0);
        step();
        midc();
        chk("startup r+6 gate_l", 32'(bus.gate_l), 32'h7);

        // Leg A L->H with dt=5: l falls n+1, h rises n+6.
        step();
        bus.pwm_in[0] = 1'b1;
        step(); midc();
        chk("t1 n+1 gate_l0", 32'(bus.gate_l[0]), 32'd0);
        chk("t1 n+1 gate_h0", 32'(bus.gate_h[0]), 32'd0);
        repeat (4) step();
        midc();
        chk("t1 n+5 gate_h0", 32'(bus.gate_h[0]), 32'd0);
        step(); midc();
        chk("t1 n+6 gate_h0", 32'(bus.gate_h[0]), 32'd1);
        // Mirror: H->L.
        step();
        bus.pwm_in[0] = 1'b0;
        step(); midc();
        chk("t1r m+1 gate_h0", 32'(bus.gate_h[0]), 32'd0);
        repeat (4) step();
        midc();
        chk("t1r m+5 gate_l0", 32'(bus.gate_l[0]), 32'd0);
        step(); midc();
        chk("t1r m+6 gate_l0", 32'(bus.gate_l[0]), 32'd1);

        // dt=0, 50% square at period 20 on all legs.
        bus.dt_cycles = 8'd0;
        for (int c = 0; c < 100; c++) begin
            step();
            bus.pwm_in = (((c / 10) % 2) == 0) ? 3'b111 : 3'b000;
        end
        step();
        bus.pwm_in = 3'b111;
        repeat (4) step();
        bus.pwm_in = 3'b000;
        step(); midc();
        chk("t2 n+1 gate_h", 32'(bus.gate_h), 32'd0);
        chk("t2 n+1 gate_l", 32'(bus.gate_l), 32'd0);
        step(); midc();
        chk("t2 n+2 gate_l", 32'(bus.gate_l), 32'h7);

        // dt=10, leg B aborts a gap after 3 cycles.
        bus.dt_cycles = 8'd10;
        step();
        bus.pwm_in = 3'b111;
        wait_gates("t3 settle high", 3'b111, 3'b000, 40);
        bus.pwm_in[1] = 1'b0;
        step(); midc();
        chk("t3 n+1 gate_h1", 32'(bus.gate_h[1]), 32'd0);
        chk("t3 n+1 gate_l1", 32'(bus.gate_l[1]), 32'd0);
        step(); midc();
        chk("t3 n+2 gate_l1", 32'(bus.gate_l[1]), 32'd0);
        step();
        bus.pwm_in[1] = 1'b1;
        midc();
        chk("t3 n+3 gate_l1", 32'(bus.gate_l[1]), 32'd0);
        step(); midc();
        chk("t3 n+4 gate_h1", 32'(bus.gate_h[1]), 32'd1);
        chk("t3 n+4 gate_l1", 32'(bus.gate_l[1]), 32'd0);

        // Fault trip, clear ignored while fault high, then clean clear.
        bus.dt_cycles = 8'd4;
        step();
        bus.fault = 1'b1;
        step();
        bus.fault = 1'b0;
        midc();
        chk("t4 trip fault_lat", 32'(bus.fault_lat), 32'd1);
        chk("t4 trip gate_h", 32'(bus.gate_h), 32'd0);
        chk("t4 trip gate_l", 32'(bus.gate_l), 32'd0);
        step();
        bus.fault = 1'b1;
        bus.fault_clr = 1'b1;
        step();
        bus.fault = 1'b0;
        bus.fault_clr = 1'b0;
        midc();
        chk("t4 clr ignored", 32'(bus.fault_lat), 32'd1);
        step();
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        midc();
        chk("t4 cleared", 32'(bus.fault_lat), 32'd0);
        chk("t4 c+1 gate_h", 32'(bus.gate_h), 32'd0);
        repeat (4) step();
        midc();
        chk("t4 c+5 gate_h", 32'(bus.gate_h), 32'd0);
        step(); midc();
        chk("t4 c+6 gate_h", 32'(bus.gate_h), 32'h7);

        // Async reset in the middle of a gap.
        step();
        bus.pwm_in = 3'b000;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t5 async gate_h", 32'(bus.gate_h), 32'd0);
        chk("t5 async gate_l", 32'(bus.gate_l), 32'd0);
        step();
        rst = 1'b0;
        repeat (4) step();
        midc();
        chk("t5 r+4 gate_l", 32'(bus.gate_l), 32'd0);
        step(); midc();
        chk("t5 r+5 gate_l", 32'(bus.gate_l), 32'h7);

        // Enable drop and restart.
        step();
        bus.en = 1'b0;
        step(); midc();
        chk("t5 en drop gate_l", 32'(bus.gate_l), 32'd0);
        step();
        bus.en = 1'b1;
        repeat (4) step();
        midc();
        chk("t5 en e+4 gate_l", 32'(bus.gate_l), 32'd0);
        step(); midc();
        chk("t5 en e+5 gate_l", 32'(bus.gate_l), 32'h7);

        // Randomized stimulus; the compare process checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 5) == 0)
                bus.pwm_in = bus.pwm_in ^ 3'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0)
                bus.dt_cycles = 8'($urandom_range(0, 12));
            bus.en        = ($urandom_range(0, 149) != 0);
            bus.fault     = ($urandom_range(0, 399) == 0);
            bus.fault_clr = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 999) == 0);
        end
        step();
        rst = 1'b0;
        step();
        midc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
